// File: rtl/vx_core_mem_bridge.sv
// -----------------------------------------------------------------------------
// vx_core_mem_bridge
//
// Bridges a core's single flat memory port onto NUM_CHANNELS address-
// interleaved memory channels.
//   * Request path : the low CH_BITS of the line address pick the channel.
//                    The remaining upper bits are forwarded. Each channel has a
//                    1-entry output register, so request latency is 1 cycle.
//   * Credits      : each channel counts its outstanding reads. A read to a
//                    channel whose count is MAX_PENDING is held off. Writes
//                    need no credit and produce no response.
//   * Response path: a round-robin arbiter merges the channel responses into a
//                    1-entry output register, so response latency is 1 cycle.
//                    Ordering holds only within a channel. The core matches
//                    responses by tag.
//
// Ports
//   clk, reset          clock, synchronous active-high reset
//   core_req_*          core request (valid/ready handshake)
//   core_rsp_*          merged response stream (valid/ready handshake)
//   mem_req_*           per-channel requests, address = core addr >> CH_BITS
//   mem_rsp_*           per-channel responses
//   busy                any outstanding read, buffered request or response
//
// Optional build macro
//   MEM_BRIDGE_PERF_EN  adds the 64-bit counters perf_reads, perf_writes and
//                       perf_credit_stalls.
// -----------------------------------------------------------------------------
module vx_core_mem_bridge #(
  parameter  int NUM_CHANNELS = 2,
  parameter  int DATA_WIDTH   = 512,
  parameter  int ADDR_WIDTH   = 26,
  parameter  int TAG_WIDTH    = 8,
  parameter  int MAX_PENDING  = 16,
  localparam int CH_BITS      = $clog2(NUM_CHANNELS),
  localparam int BE_W         = DATA_WIDTH / 8,
  localparam int MEM_ADDR_W   = ADDR_WIDTH - CH_BITS
) (
  input  logic                                    clk,
  input  logic                                    reset,

  input  logic                                    core_req_valid,
  input  logic                                    core_req_rw,
  input  logic [BE_W-1:0]                         core_req_byteen,
  input  logic [ADDR_WIDTH-1:0]                   core_req_addr,
  input  logic [DATA_WIDTH-1:0]                   core_req_data,
  input  logic [TAG_WIDTH-1:0]                    core_req_tag,
  output logic                                    core_req_ready,

  output logic                                    core_rsp_valid,
  output logic [DATA_WIDTH-1:0]                   core_rsp_data,
  output logic [TAG_WIDTH-1:0]                    core_rsp_tag,
  input  logic                                    core_rsp_ready,

  output logic [NUM_CHANNELS-1:0]                 mem_req_valid,
  output logic [NUM_CHANNELS-1:0]                 mem_req_rw,
  output logic [NUM_CHANNELS-1:0][BE_W-1:0]       mem_req_byteen,
  output logic [NUM_CHANNELS-1:0][MEM_ADDR_W-1:0] mem_req_addr,
  output logic [NUM_CHANNELS-1:0][DATA_WIDTH-1:0] mem_req_data,
  output logic [NUM_CHANNELS-1:0][TAG_WIDTH-1:0]  mem_req_tag,
  input  logic [NUM_CHANNELS-1:0]                 mem_req_ready,

  input  logic [NUM_CHANNELS-1:0]                 mem_rsp_valid,
  input  logic [NUM_CHANNELS-1:0][DATA_WIDTH-1:0] mem_rsp_data,
  input  logic [NUM_CHANNELS-1:0][TAG_WIDTH-1:0]  mem_rsp_tag,
  output logic [NUM_CHANNELS-1:0]                 mem_rsp_ready,

`ifdef MEM_BRIDGE_PERF_EN
  output logic [63:0]                             perf_reads,
  output logic [63:0]                             perf_writes,
  output logic [63:0]                             perf_credit_stalls,
`endif
  output logic                                    busy
);

  // A single channel still needs a 1-bit index vector.
  localparam int CH_W   = (CH_BITS > 0) ? CH_BITS : 1;
  localparam int PEND_W = $clog2(MAX_PENDING) + 1;
  localparam logic [PEND_W-1:0] PEND_MAX = PEND_W'(MAX_PENDING);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [NUM_CHANNELS-1:0]                 req_valid_q,  req_valid_d;
  logic [NUM_CHANNELS-1:0]                 req_rw_q,     req_rw_d;
  logic [NUM_CHANNELS-1:0][BE_W-1:0]       req_byteen_q, req_byteen_d;
  logic [NUM_CHANNELS-1:0][MEM_ADDR_W-1:0] req_addr_q,   req_addr_d;
  logic [NUM_CHANNELS-1:0][DATA_WIDTH-1:0] req_data_q,   req_data_d;
  logic [NUM_CHANNELS-1:0][TAG_WIDTH-1:0]  req_tag_q,    req_tag_d;
  logic [NUM_CHANNELS-1:0][PEND_W-1:0]     pending_q,    pending_d;
  logic                                    rsp_valid_q,  rsp_valid_d;
  logic [DATA_WIDTH-1:0]                   rsp_data_q,   rsp_data_d;
  logic [TAG_WIDTH-1:0]                    rsp_tag_q,    rsp_tag_d;
  logic [CH_W-1:0]                         rr_q,         rr_d;

  // ---------------------------------------------------------------------------
  // Channel select and forwarded address
  // ---------------------------------------------------------------------------
  logic [CH_W-1:0]       req_ch;
  logic [MEM_ADDR_W-1:0] req_addr_fwd;

  generate
    if (CH_BITS == 0) begin : g_single_ch
      assign req_ch       = '0;
      assign req_addr_fwd = core_req_addr;
    end else begin : g_multi_ch
      assign req_ch       = core_req_addr[CH_BITS-1:0];
      assign req_addr_fwd = core_req_addr[ADDR_WIDTH-1:CH_BITS];
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Request acceptance: the target slot must be free or draining this cycle,
  // and reads also need a credit.
  // ---------------------------------------------------------------------------
  logic [NUM_CHANNELS-1:0] ch_sel;
  logic [NUM_CHANNELS-1:0] slot_free;
  logic [NUM_CHANNELS-1:0] credit_ok;
  logic                    req_accept;

  // NOTE: every signal driven in an always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    ch_sel         = '0;
    slot_free      = '0;
    credit_ok      = '0;
    core_req_ready = 1'b0;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      ch_sel[i]    = (int'(req_ch) == i);
      slot_free[i] = !req_valid_q[i] || mem_req_ready[i];
      credit_ok[i] = pending_q[i] < PEND_MAX;
      if (ch_sel[i]) core_req_ready = slot_free[i] && (core_req_rw || credit_ok[i]);
    end
  end

  assign req_accept = core_req_valid && core_req_ready;

  always_comb begin
    req_valid_d  = req_valid_q;
    req_rw_d     = req_rw_q;
    req_byteen_d = req_byteen_q;
    req_addr_d   = req_addr_q;
    req_data_d   = req_data_q;
    req_tag_d    = req_tag_q;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      if (mem_req_ready[i]) req_valid_d[i] = 1'b0;
      // A new request may land in the same cycle the old one drains.
      if (req_accept && ch_sel[i]) begin
        req_valid_d[i]  = 1'b1;
        req_rw_d[i]     = core_req_rw;
        req_byteen_d[i] = core_req_byteen;
        req_addr_d[i]   = req_addr_fwd;
        req_data_d[i]   = core_req_data;
        req_tag_d[i]    = core_req_tag;
      end
    end
  end

  assign mem_req_valid  = req_valid_q;
  assign mem_req_rw     = req_rw_q;
  assign mem_req_byteen = req_byteen_q;
  assign mem_req_addr   = req_addr_q;
  assign mem_req_data   = req_data_q;
  assign mem_req_tag    = req_tag_q;

  // ---------------------------------------------------------------------------
  // Round-robin response arbiter. A channel's priority is its distance from
  // rr_q (mod NUM_CHANNELS), and the nearest valid channel wins.
  // ---------------------------------------------------------------------------
  logic [NUM_CHANNELS-1:0] grant;
  logic [CH_W-1:0]         grant_idx;
  logic                    grant_any;
  logic                    rsp_load;
  logic [NUM_CHANNELS-1:0] rsp_fire;
  logic [DATA_WIDTH-1:0]   sel_data;
  logic [TAG_WIDTH-1:0]    sel_tag;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    for (int k = 0; k < NUM_CHANNELS; k++) begin
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        if (!grant_any && mem_rsp_valid[i] && ((CH_W'(i) - rr_q) == CH_W'(k))) begin
          grant_any = 1'b1;
          grant[i]  = 1'b1;
          grant_idx = CH_W'(i);
        end
      end
    end
  end

  assign rsp_load      = !rsp_valid_q || core_rsp_ready;
  assign mem_rsp_ready = grant & {NUM_CHANNELS{rsp_load}};
  assign rsp_fire      = mem_rsp_valid & mem_rsp_ready;

  always_comb begin
    sel_data = '0;
    sel_tag  = '0;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      if (grant[i]) begin
        sel_data = mem_rsp_data[i];
        sel_tag  = mem_rsp_tag[i];
      end
    end
  end

  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_tag_d   = rsp_tag_q;
    rr_d        = rr_q;
    if (grant_any && rsp_load) begin
      rsp_valid_d = 1'b1;
      rsp_data_d  = sel_data;
      rsp_tag_d   = sel_tag;
      rr_d        = (NUM_CHANNELS == 1) ? '0 : grant_idx + CH_W'(1);
    end else if (core_rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  assign core_rsp_valid = rsp_valid_q;
  assign core_rsp_data  = rsp_data_q;
  assign core_rsp_tag   = rsp_tag_q;

  // ---------------------------------------------------------------------------
  // Per-channel outstanding-read counters
  // ---------------------------------------------------------------------------
  always_comb begin
    pending_d = pending_q;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      if (req_accept && !core_req_rw && ch_sel[i] && !rsp_fire[i]) begin
        pending_d[i] = pending_q[i] + PEND_W'(1);
      end else if (rsp_fire[i] && !(req_accept && !core_req_rw && ch_sel[i]) &&
                   pending_q[i] != '0) begin
        pending_d[i] = pending_q[i] - PEND_W'(1);
      end
    end
  end

  always_comb begin
    busy = rsp_valid_q || (|req_valid_q);
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      if (pending_q[i] != '0) busy = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      req_valid_q <= '0;
      pending_q   <= '0;
      rsp_valid_q <= 1'b0;
      rr_q        <= '0;
    end else begin
      req_valid_q <= req_valid_d;
      pending_q   <= pending_d;
      rsp_valid_q <= rsp_valid_d;
      rr_q        <= rr_d;
    end
  end

  // NOTE: payload registers are qualified by their valid bits, so they carry no reset.
  always_ff @(posedge clk) begin
    req_rw_q     <= req_rw_d;
    req_byteen_q <= req_byteen_d;
    req_addr_q   <= req_addr_d;
    req_data_q   <= req_data_d;
    req_tag_q    <= req_tag_d;
    rsp_data_q   <= rsp_data_d;
    rsp_tag_q    <= rsp_tag_d;
  end

  // A response from a channel that has no read outstanding is a protocol error.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        assert (!(rsp_fire[i] && pending_q[i] == '0));
      end
    end
  end

`ifdef MEM_BRIDGE_PERF_EN
  // ---------------------------------------------------------------------------
  // Performance counters
  // ---------------------------------------------------------------------------
  logic [63:0] perf_reads_q,         perf_reads_d;
  logic [63:0] perf_writes_q,        perf_writes_d;
  logic [63:0] perf_credit_stalls_q, perf_credit_stalls_d;

  always_comb begin
    perf_reads_d         = perf_reads_q  + 64'(req_accept && !core_req_rw);
    perf_writes_d        = perf_writes_q + 64'(req_accept &&  core_req_rw);
    // A stall counts only when the slot is free and the sole blocker is the credit limit.
    perf_credit_stalls_d = perf_credit_stalls_q +
                           64'(core_req_valid && !core_req_rw && |(ch_sel & slot_free & ~credit_ok));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_reads_q         <= '0;
      perf_writes_q        <= '0;
      perf_credit_stalls_q <= '0;
    end else begin
      perf_reads_q         <= perf_reads_d;
      perf_writes_q        <= perf_writes_d;
      perf_credit_stalls_q <= perf_credit_stalls_d;
    end
  end

  assign perf_reads         = perf_reads_q;
  assign perf_writes        = perf_writes_q;
  assign perf_credit_stalls = perf_credit_stalls_q;
`endif

endmodule
